systolic_controller_v2: RTL and testbench

SYSTOLIC_CONTROLLER_V2 -- requirements
Module: systolic_controller_v2

---
 rtl/systolic_controller_v2.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_systolic_controller_v2.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_controller_v2.sv
// -----------------------------------------------------------------------------
// systolic_controller_v2
//
// Sequencer for an SxS weight-stationary systolic array. A run walks every
// filter group through: weight load, first IFM tile load+compute, NO_TILE-2
// overlapped load/compute/write periods, a final compute/write, and a drain.
// IFM register files are double buffered; ifm_demux/ifm_mux swap sides on
// every tile boundary.
//
// Optional feature: define SYSTOLIC_CYCLE_CNT_EN to add a 32-bit cycle_count
// output (busy, non-stalled cycles; cleared on start; saturating).
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   start                : run request, honoured only in IDLE
//   stall                : downstream backpressure, freezes the sequencer
//   load_ifm, load_wgt   : buffer load strobes
//   ifm_demux, ifm_mux   : IFM double-buffer write / read side select
//   ifm_RF_shift_en_1/2  : IFM register-file shift enables (side 0 / side 1)
//   wgt_RF_shift_en[S]   : per-column weight shift enable
//   select_wgt           : array input select (1 = weight path)
//   reset_pe             : clear PE accumulators
//   write_out_en         : result write strobe
//   busy, done           : run active / one-cycle completion pulse
//   tile_idx, filter_idx : progress indices
//   cycle_count          : (SYSTOLIC_CYCLE_CNT_EN only) active cycle count
//
// All outputs are registered and decoded from the next state/count, so an
// output observed while the sequencer sits at count k belongs to count k.
// -----------------------------------------------------------------------------
module systolic_controller_v2 #(
  parameter int unsigned NO_FILTER     = 16,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned NO_TILE       = 64,
  localparam int unsigned NF     = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE,
  localparam int unsigned TILE_W = $clog2(NO_TILE + 1),
  localparam int unsigned FILT_W = $clog2(NF + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     load_ifm,
  output logic                     load_wgt,
  output logic                     ifm_demux,
  output logic                     ifm_mux,
  output logic                     ifm_RF_shift_en_1,
  output logic                     ifm_RF_shift_en_2,
  output logic                     select_wgt,
  output logic                     reset_pe,
  output logic                     write_out_en,
  output logic [SYSTOLIC_SIZE-1:0] wgt_RF_shift_en,
  output logic                     busy,
  output logic                     done,
  output logic [TILE_W-1:0]        tile_idx,
  output logic [FILT_W-1:0]        filter_idx
`ifdef SYSTOLIC_CYCLE_CNT_EN
  ,
  output logic [31:0]              cycle_count
`endif
);

  localparam int unsigned S     = SYSTOLIC_SIZE;
  localparam int unsigned L     = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int unsigned C     = L + 2 * S - 1;
  localparam int unsigned CNT_W = $clog2(C + 3);

  localparam logic [CNT_W-1:0]  CntL       = CNT_W'(L);
  localparam logic [CNT_W-1:0]  CntLm1     = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0]  CntLwLast  = CNT_W'(L + 2);
  localparam logic [CNT_W-1:0]  CntC       = CNT_W'(C);
  localparam logic [CNT_W-1:0]  CntC1      = CNT_W'(C + 1);
  localparam logic [CNT_W-1:0]  CntC2      = CNT_W'(C + 2);
  localparam logic [CNT_W-1:0]  CntSm1     = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0]  CntSm2     = CNT_W'(S - 2);
  localparam logic [CNT_W-1:0]  CntWrLast  = CNT_W'(S + 1);
  localparam logic [TILE_W-1:0] TileLcwEnd = TILE_W'(NO_TILE - 2);
  localparam logic [FILT_W-1:0] FiltNf     = FILT_W'(NF);

  typedef enum logic [2:0] {
    StIdle,
    StLoadWeight,
    StLoadCompute,
    StLoadComputeWrite,
    StComputeWrite,
    StWrite
  } state_e;

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [TILE_W-1:0]   r_tile, w_tile_d;
  logic [FILT_W-1:0]   r_filter, w_filter_d;
  logic                w_done_d;

  logic                r_load_ifm, w_load_ifm_d;
  logic                r_load_wgt, w_load_wgt_d;
  logic                r_ifm_demux, w_ifm_demux_d;
  logic                r_ifm_mux, w_ifm_mux_d;
  logic                r_sh1, w_sh1_d;
  logic                r_sh2, w_sh2_d;
  logic                r_select_wgt, w_select_wgt_d;
  logic                r_reset_pe, w_reset_pe_d;
  logic                r_write, w_write_d;
  logic [S-1:0]        r_wgt, w_wgt_d;
  logic                r_busy, w_busy_d;
  logic                r_done;

  // Column i weight shift window: i <= cnt < L+i (diagonal skew across columns).
  logic [31:0]         w_cnt_ext;
  logic [S-1:0]        w_wgt_win;
  assign w_cnt_ext = 32'(w_cnt_d);
  for (genvar g = 0; g < S; g++) begin : g_wgt_win
    assign w_wgt_win[g] = (w_cnt_ext >= 32'(g)) && (w_cnt_ext < 32'(L + g));
  end

  // Next state and counters
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_tile_d   = r_tile;
    w_filter_d = r_filter;
    w_done_d   = 1'b0;
    if (!stall) begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_state_d  = StLoadWeight;
            w_cnt_d    = '0;
            w_tile_d   = '0;
            w_filter_d = '0;
          end
        end
        StLoadWeight: begin
          if (r_cnt == CntLm1) w_filter_d = r_filter + 1'b1;
          if (r_cnt == CntLwLast) begin
            w_state_d = StLoadCompute;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StLoadCompute: begin
          if (r_cnt == CntC2) begin
            w_tile_d  = r_tile + 1'b1;
            w_cnt_d   = '0;
            // With only two tiles there is no overlapped phase.
            w_state_d = (NO_TILE > 2) ? StLoadComputeWrite : StComputeWrite;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StLoadComputeWrite: begin
          if (r_cnt == CntC1) begin
            w_tile_d = r_tile + 1'b1;
            w_cnt_d  = '0;
            if (r_tile == TileLcwEnd) w_state_d = StComputeWrite;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StComputeWrite: begin
          if (r_cnt == CntC2) begin
            w_tile_d  = r_tile + 1'b1;
            w_cnt_d   = '0;
            w_state_d = StWrite;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StWrite: begin
          if (r_cnt == CntWrLast) begin
            w_cnt_d = '0;
            if (r_filter < FiltNf) begin
              w_state_d = StLoadWeight;
              w_tile_d  = '0;
            end else begin
              w_state_d = StIdle;
              w_done_d  = 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Output decode from the next state/count
  always_comb begin
    w_load_ifm_d   = 1'b0;
    w_load_wgt_d   = 1'b0;
    w_sh1_d        = 1'b0;
    w_sh2_d        = 1'b0;
    w_wgt_d        = '0;
    w_reset_pe_d   = 1'b0;
    w_write_d      = 1'b0;
    w_ifm_demux_d  = r_ifm_demux;
    w_ifm_mux_d    = r_ifm_mux;
    w_select_wgt_d = r_select_wgt;
    w_busy_d       = (w_state_d != StIdle);
    if (!stall) begin
      unique case (w_state_d)
        StIdle: begin
          w_ifm_demux_d  = 1'b0;
          w_ifm_mux_d    = 1'b1;
          w_select_wgt_d = 1'b1;
        end
        StLoadWeight: begin
          w_load_wgt_d   = (w_cnt_d <= CntL);
          w_load_ifm_d   = 1'b1;
          w_sh1_d        = 1'b1;
          w_wgt_d        = '1;
          w_select_wgt_d = 1'b1;
          w_ifm_mux_d    = 1'b1;
          w_ifm_demux_d  = 1'b0;
        end
        StLoadCompute: begin
          w_load_ifm_d   = (w_cnt_d < CntL);
          w_sh2_d        = (w_cnt_d <= CntL);
          w_ifm_demux_d  = 1'b1;
          w_ifm_mux_d    = 1'b0;
          w_select_wgt_d = 1'b0;
          w_wgt_d        = w_wgt_win;
          w_reset_pe_d   = (w_cnt_d == CntC);
          w_write_d      = (w_cnt_d == CntC1);
        end
        StLoadComputeWrite: begin
          // Count 0 here is only reached on a fresh period, never while held.
          if (w_cnt_d == '0) begin
            w_ifm_demux_d = ~r_ifm_demux;
            w_ifm_mux_d   = ~r_ifm_mux;
          end
          w_select_wgt_d = 1'b0;
          w_load_ifm_d   = (w_cnt_d < CntL);
          // Shift the register file currently being filled.
          if (w_cnt_d <= CntL) begin
            if (w_ifm_demux_d) w_sh2_d = 1'b1;
            else               w_sh1_d = 1'b1;
          end
          w_wgt_d      = w_wgt_win;
          w_reset_pe_d = (w_cnt_d == CntC);
          w_write_d    = (w_cnt_d <= CntSm2) || (w_cnt_d == CntC1);
        end
        StComputeWrite: begin
          if (w_cnt_d == '0) begin
            w_ifm_demux_d = ~r_ifm_demux;
            w_ifm_mux_d   = ~r_ifm_mux;
          end
          w_select_wgt_d = 1'b0;
          w_wgt_d        = w_wgt_win;
          w_write_d      = (w_cnt_d <= CntSm1);
        end
        StWrite: begin
          w_select_wgt_d = 1'b0;
          w_reset_pe_d   = 1'b1;
          w_write_d      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_tile       <= '0;
      r_filter     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_load_ifm   <= 1'b0;
      r_load_wgt   <= 1'b0;
      r_ifm_demux  <= 1'b0;
      r_ifm_mux    <= 1'b1;
      r_sh1        <= 1'b0;
      r_sh2        <= 1'b0;
      r_select_wgt <= 1'b1;
      r_reset_pe   <= 1'b0;
      r_write      <= 1'b0;
      r_wgt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_tile       <= w_tile_d;
      r_filter     <= w_filter_d;
      r_done       <= w_done_d;
      r_busy       <= w_busy_d;
      r_load_ifm   <= w_load_ifm_d;
      r_load_wgt   <= w_load_wgt_d;
      r_ifm_demux  <= w_ifm_demux_d;
      r_ifm_mux    <= w_ifm_mux_d;
      r_sh1        <= w_sh1_d;
      r_sh2        <= w_sh2_d;
      r_select_wgt <= w_select_wgt_d;
      r_reset_pe   <= w_reset_pe_d;
      r_write      <= w_write_d;
      r_wgt        <= w_wgt_d;
    end
  end

  assign load_ifm          = r_load_ifm;
  assign load_wgt          = r_load_wgt;
  assign ifm_demux         = r_ifm_demux;
  assign ifm_mux           = r_ifm_mux;
  assign ifm_RF_shift_en_1 = r_sh1;
  assign ifm_RF_shift_en_2 = r_sh2;
  assign select_wgt        = r_select_wgt;
  assign reset_pe          = r_reset_pe;
  assign write_out_en      = r_write;
  assign wgt_RF_shift_en   = r_wgt;
  assign busy              = r_busy;
  assign done              = r_done;
  assign tile_idx          = r_tile;
  assign filter_idx        = r_filter;

`ifdef SYSTOLIC_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (r_state == StIdle && start && !stall) begin
      r_cycle_count <= '0;
    end else if (r_state != StIdle && !stall && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end
  assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_systolic_controller_v2.sv
module tb_systolic_controller_v2;

  localparam int unsigned S    = 16;
  localparam int unsigned KS   = 3;
  localparam int unsigned CH   = 3;
  localparam int unsigned NT   = 64;
  localparam int unsigned NOF  = 16;
  localparam int unsigned L    = KS * KS * CH;
  localparam int unsigned C    = L + 2 * S - 1;
  localparam int unsigned NF   = (NOF + S - 1) / S;
  localparam int unsigned RUN  = NF * ((L + 3) + 2 * (C + 3) + (NT - 2) * (C + 2) + S + 2);
  localparam int unsigned NOF2 = 40;
  localparam int unsigned NT2  = 4;
  localparam int unsigned NF2  = (NOF2 + S - 1) / S;
  localparam int unsigned RUN2 = NF2 * ((L + 3) + 2 * (C + 3) + (NT2 - 2) * (C + 2) + S + 2);
  localparam int unsigned TW   = $clog2(NT + 1);
  localparam int unsigned FW   = $clog2(NF + 1);
  localparam int unsigned TW2  = $clog2(NT2 + 1);
  localparam int unsigned FW2  = $clog2(NF2 + 1);

  logic clk, rst, start, start2, stall;

  logic          load_ifm, load_wgt, ifm_demux, ifm_mux, sh1, sh2, select_wgt;
  logic          reset_pe, write_out_en, busy, done;
  logic [S-1:0]  wgt;
  logic [TW-1:0] tile_idx;
  logic [FW-1:0] filter_idx;

  logic           b_load_ifm, b_load_wgt, b_ifm_demux, b_ifm_mux, b_sh1, b_sh2, b_select_wgt;
  logic           b_reset_pe, b_write_out_en, b_busy, b_done;
  logic [S-1:0]   b_wgt;
  logic [TW2-1:0] b_tile_idx;
  logic [FW2-1:0] b_filter_idx;
`ifdef SYSTOLIC_CYCLE_CNT_EN
  logic [31:0] cycle_count, b_cycle_count;
`endif

  systolic_controller_v2 #(
    .NO_FILTER(NOF), .KERNEL_SIZE(KS), .NO_CHANNEL(CH), .SYSTOLIC_SIZE(S), .NO_TILE(NT)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .load_ifm(load_ifm), .load_wgt(load_wgt), .ifm_demux(ifm_demux), .ifm_mux(ifm_mux),
    .ifm_RF_shift_en_1(sh1), .ifm_RF_shift_en_2(sh2), .select_wgt(select_wgt),
    .reset_pe(reset_pe), .write_out_en(write_out_en), .wgt_RF_shift_en(wgt),
    .busy(busy), .done(done), .tile_idx(tile_idx), .filter_idx(filter_idx)
`ifdef SYSTOLIC_CYCLE_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  systolic_controller_v2 #(
    .NO_FILTER(NOF2), .KERNEL_SIZE(KS), .NO_CHANNEL(CH), .SYSTOLIC_SIZE(S), .NO_TILE(NT2)
  ) u_dut_nf (
    .clk(clk), .rst(rst), .start(start2), .stall(stall),
    .load_ifm(b_load_ifm), .load_wgt(b_load_wgt), .ifm_demux(b_ifm_demux),
    .ifm_mux(b_ifm_mux), .ifm_RF_shift_en_1(b_sh1), .ifm_RF_shift_en_2(b_sh2),
    .select_wgt(b_select_wgt), .reset_pe(b_reset_pe), .write_out_en(b_write_out_en),
    .wgt_RF_shift_en(b_wgt), .busy(b_busy), .done(b_done), .tile_idx(b_tile_idx),
    .filter_idx(b_filter_idx)
`ifdef SYSTOLIC_CYCLE_CNT_EN
    , .cycle_count(b_cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests, n_fail, cyc, t0, t_done;
  int unsigned exp_q[$];
  int          first_hi, last_hi, n_hi, rpe_at, wr_at, n_wr, n_nz, n_bad, n_d, n_lw;
  logic        seen, prev;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int unsigned t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done on the default instance and scores its arrival cycle.
  task automatic wait_done(input string tag);
    seen = 1'b0;
    for (int unsigned k = 0; k < RUN + 200 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    if (exp_q.size() != 0) check({tag, "_cycle"}, cyc, exp_q.pop_front());
    else check({tag, "_scoreboard"}, 1, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; stall = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_mux_sel", {ifm_mux, select_wgt, ifm_demux}, 3'b110);
    check("rst_enables", {load_ifm, load_wgt, sh1, sh2, wgt, reset_pe, write_out_en}, 0);
    check("rst_idx", {tile_idx, filter_idx}, 0);
    rst = 1'b0;
    tick();

    // Run 1: clean run, plus a start pulse while busy
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc; exp_q.push_back(t0 + RUN);
    check("lw_first", {load_wgt, load_ifm, sh1, sh2, select_wgt, ifm_mux, ifm_demux, busy},
          8'b1110_1101);
    check("lw_wgt_all", wgt, {S{1'b1}});
    step_to(t0 + L);
    check("lw_load_wgt_last", load_wgt, 1);
    tick();
    check("lw_load_wgt_off", load_wgt, 0);
    step_to(t0 + L + 2);
    check("lw_filter_idx", filter_idx, 1);
    check("lw_tile_idx", tile_idx, 0);

    step_to(t0 + L + 3);
    check("lc_mux", {ifm_demux, ifm_mux, select_wgt}, 3'b100);
    first_hi = -1; last_hi = -1; n_hi = 0; rpe_at = -1; wr_at = -1; n_wr = 0;
    for (int j = 0; j < int'(C + 3); j++) begin
      if (j > 0) tick();
      if (wgt[S-1]) begin
        if (first_hi < 0) first_hi = j;
        last_hi = j;
        n_hi++;
      end
      if (reset_pe) rpe_at = j;
      if (write_out_en) begin wr_at = j; n_wr++; end
    end
    check("lc_wgt15_first", first_hi, S - 1);
    check("lc_wgt15_last", last_hi, L + S - 2);
    check("lc_wgt15_count", n_hi, L);
    check("lc_reset_pe_at", rpe_at, C);
    check("lc_write_at", wr_at, C + 1);
    check("lc_write_count", n_wr, 1);

    tick();
    check("lcw0_mux", {ifm_demux, ifm_mux}, 2'b01);
    check("lcw0_write", write_out_en, 1);
    check("lcw0_tile", tile_idx, 1);
    step_to(t0 + L + 3 + C + 3 + S - 2);
    check("lcw_write_last", write_out_en, 1);
    tick();
    check("lcw_write_off", write_out_en, 0);
    step_to(t0 + L + 3 + C + 3 + C + 2);
    check("lcw1_mux", {ifm_demux, ifm_mux}, 2'b10);
    check("lcw1_tile", tile_idx, 2);

    tick(); start = 1'b1; tick(); start = 1'b0;
    wait_done("run1_done");
    tick();
    check("run1_done_pulse", {done, busy}, 2'b00);
    check("run1_idle_mux_sel", {ifm_mux, select_wgt}, 2'b11);
    check("run1_idx", {tile_idx, filter_idx}, {TW'(NT), FW'(NF)});
    tick(); tick();
    check("run1_stays_idle", busy, 0);

    // Run 2: 10-cycle stall at load-compute count 20
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc; exp_q.push_back(t0 + RUN + 10);
    step_to(t0 + L + 3 + 20);
    stall = 1'b1;
    n_nz = 0; n_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ({load_ifm, load_wgt, sh1, sh2, wgt, reset_pe, write_out_en} != '0) n_nz++;
      if ({ifm_demux, ifm_mux, select_wgt, busy} != 4'b1001) n_bad++;
    end
    check("stall_enables_zero", n_nz, 0);
    check("stall_hold", n_bad, 0);
    stall = 1'b0;
    tick();
    check("stall_resume", {load_ifm, sh2, wgt}, {2'b11, {S{1'b1}}});
    step_to(t0 + L + 3 + C + 10);
    check("stall_reset_pe_pos", {reset_pe, write_out_en}, 2'b10);
    tick();
    check("stall_write_pos", {reset_pe, write_out_en}, 2'b01);
    wait_done("run2_done");

    // Run 3: reset during load-compute-write aborts without done
    tick();
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    step_to(t0 + L + 3 + C + 3 + 10);
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_mux_sel", {ifm_mux, select_wgt, ifm_demux}, 3'b110);
    check("abort_enables", {load_ifm, load_wgt, sh1, sh2, wgt, reset_pe, write_out_en}, 0);
    check("abort_idx", {tile_idx, filter_idx}, 0);
    n_d = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) n_d++;
    end
    rst = 1'b0;
    tick();
    if (done) n_d++;
    check("abort_no_done", n_d, 0);
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc; exp_q.push_back(t0 + RUN);
    step_to(t0 + L + 2);
    check("restart_filter_idx", filter_idx, 1);
    wait_done("run3_done");

    // Run 4: NO_FILTER=40 instance runs three filter groups
    tick();
    start2 = 1'b1; tick(); start2 = 1'b0;
    t0 = cyc; exp_q.push_back(t0 + RUN2);
    n_lw = b_load_wgt ? 1 : 0;
    prev = b_load_wgt;
    n_d = 0; t_done = 0;
    for (int unsigned k = 0; k < RUN2 + 20; k++) begin
      tick();
      if (b_load_wgt && !prev) n_lw++;
      prev = b_load_wgt;
      if (b_done) begin n_d++; t_done = cyc; end
    end
    check("nf_load_weight_passes", n_lw, NF2);
    check("nf_done_pulses", n_d, 1);
    check("nf_done_cycle", t_done, exp_q.pop_front());
    check("nf_filter_idx", b_filter_idx, NF2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
